// File: rtl/wb_pkg.sv
// Wishbone width constants, slave FSM state encoding and the latched request record.
package wb_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic             we;
      logic [SEL_W-1:0] sel;
      logic [DAT_W-1:0] dat;
   } req_t;

endpackage

// File: rtl/sram_bytewrite.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
module sram_bytewrite
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic [AW-1:0]    addr_i,
   input  logic             re_i,
   input  logic [SEL_W-1:0] we_i,
   input  logic [DAT_W-1:0] wdata_i,
   output logic [DAT_W-1:0] rdata_o
);

   logic [DAT_W-1:0] mem_q [DEPTH];
   logic [DAT_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < SEL_W; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram.sv
// Wishbone classic slave wrapping a byte-writable SRAM, with optional wait states,
// a write-protected low region and error termination for bad addresses.
module wb_sram
   import wb_pkg::*;
#(
   parameter logic [ADR_W-1:0] BASE_ADDRESS = '0,
   parameter int unsigned      DEPTH        = 4096,
   parameter int unsigned      WAIT_STATES  = 0,
   parameter int unsigned      ROM_WORDS    = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cyc_i,
   input  logic             stb_i,
   input  logic             we_i,
   input  logic [ADR_W-1:0] adr_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [DAT_W-1:0] dat_i,
   output logic [DAT_W-1:0] dat_o,
   output logic             ack_o,
   output logic             err_o,
   output logic             rty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [ADR_W:0] BASE33  = {1'b0, BASE_ADDRESS};
   localparam logic [ADR_W:0] LIMIT33 = BASE33 + (ADR_W+1)'(4 * DEPTH);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             err_q, err_d;
   logic             rd_q, rd_d;

   req_t             bus_req, cur;
   logic [ADR_W:0]   addr33;
   logic [ADR_W-3:0] word_off;
   logic             bad;
   logic             enter_resp;
   logic [SEL_W-1:0] ram_we;
   logic             ram_re;
   logic [DAT_W-1:0] ram_rdata;

   assign bus_req = '{adr: adr_i, we: we_i, sel: sel_i, dat: dat_i};

   // With no wait states the RESP-entry edge is also the latch edge, so the
   // bus is used directly in IDLE; elsewhere the latched copy is used.
   always_comb begin
      cur      = (state_q == IDLE) ? bus_req : req_q;
      addr33   = {1'b0, cur.adr};
      word_off = cur.adr[ADR_W-1:2] - BASE_ADDRESS[ADR_W-1:2];
      bad      = (addr33 < BASE33) || (addr33 >= LIMIT33) || (cur.adr[1:0] != 2'b00) ||
                 (cur.we && ({2'b00, word_off} < ADR_W'(ROM_WORDS)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      rd_d    = rd_q;
      unique case (state_q)
         IDLE: begin
            if (cyc_i && stb_i) begin
               req_d = bus_req;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!(cyc_i && stb_i)) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == RESP) begin
         err_d = bad;
         rd_d  = !cur.we && !bad;
      end
   end

   assign enter_resp = (state_d == RESP) && !rst_i;
   assign ram_we     = (enter_resp && cur.we && !bad) ? cur.sel : '0;
   assign ram_re     = enter_resp && !cur.we && !bad;

   sram_bytewrite #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .addr_i  (word_off[AW-1:0]),
      .re_i    (ram_re),
      .we_i    (ram_we),
      .wdata_i (cur.dat),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      ack_o = (state_q == RESP) && !err_q;
      err_o = (state_q == RESP) && err_q;
      rty_o = 1'b0;
      dat_o = ((state_q == RESP) && rd_q) ? ram_rdata : '0;
   end

endmodule

// File: tb/tb_wb_sram.sv
// Directed bench for wb_sram: three instances (no wait / 3 wait states / 2 ROM words).
module tb_wb_sram;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc [3];
   logic        stb [3];
   logic        we  [3];
   logic [31:0] adr [3];
   logic [3:0]  sel [3];
   logic [31:0] dwr [3];
   logic [31:0] drd [3];
   logic        ack [3];
   logic        err [3];
   logic        rty [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_sram #(.BASE_ADDRESS(32'h1000), .DEPTH(16), .WAIT_STATES(0), .ROM_WORDS(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .adr_i(adr[0]),
      .sel_i(sel[0]), .dat_i(dwr[0]), .dat_o(drd[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]));

   wb_sram #(.BASE_ADDRESS(32'h1000), .DEPTH(16), .WAIT_STATES(3), .ROM_WORDS(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .adr_i(adr[1]),
      .sel_i(sel[1]), .dat_i(dwr[1]), .dat_o(drd[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]));

   wb_sram #(.BASE_ADDRESS(32'h1000), .DEPTH(16), .WAIT_STATES(0), .ROM_WORDS(2)) dut_c (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]), .adr_i(adr[2]),
      .sel_i(sel[2]), .dat_i(dwr[2]), .dat_o(drd[2]), .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2]));

   typedef struct packed {
      logic [1:0]  d;
      logic        w;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] wd;
      logic        eack;
      logic        eerr;
      logic [31:0] erd;
      logic [7:0]  elat;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [1:0] d, input logic w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] wd, input logic eack,
                               input logic eerr, input logic [31:0] erd, input logic [7:0] elat);
      mk = '{d: d, w: w, a: a, s: s, wd: wd, eack: eack, eerr: eerr, erd: erd, elat: elat};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output logic gack, output logic gerr,
                       output logic [31:0] rd, output int lat, output logic tail);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dwr[d] = wd;
      gack = 1'b0; gerr = 1'b0; rd = '0; lat = 99;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ack[d] || err[d]) begin
            gack = ack[d]; gerr = err[d]; rd = drd[d]; lat = i;
            break;
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      @(negedge clk);
      tail = ack[d] | err[d] | (drd[d] != '0);
   endtask

   task automatic watch_quiet(input int d, input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ack[d] || err[d]) hits++;
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic        gack, gerr, tail;
      logic [31:0] rd;
      int          lat, hits, nack, consec, baddat;
      logic        prev;

      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; sel[d] = '0; dwr[d] = '0;
      end
      rst = 1'b1;

      vt.push_back(mk(0, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 1, 32'h1004, 4'hF, 32'hDEADBEEF, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1004, 4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 1));
      vt.push_back(mk(0, 1, 32'h1008, 4'hF, 32'h11223344, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 1, 32'h1008, 4'h5, 32'hAABBCCDD, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1008, 4'h0, 32'h0,        1, 0, 32'h11BB33DD, 1));
      vt.push_back(mk(0, 1, 32'h1008, 4'h0, 32'h12345678, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1008, 4'hF, 32'h0,        1, 0, 32'h11BB33DD, 1));
      vt.push_back(mk(0, 0, 32'h0FFC, 4'hF, 32'h0,        0, 1, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1040, 4'hF, 32'h0,        0, 1, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1002, 4'hF, 32'h0,        0, 1, 32'h0,        1));
      vt.push_back(mk(0, 1, 32'h1040, 4'hF, 32'hFFFFFFFF, 0, 1, 32'h0,        1));
      vt.push_back(mk(0, 1, 32'h1002, 4'hF, 32'hFFFFFFFF, 0, 1, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h1000, 4'hF, 32'h0,        1, 0, 32'hCAFEF00D, 1));
      vt.push_back(mk(0, 1, 32'h103C, 4'hF, 32'h0BADF00D, 1, 0, 32'h0,        1));
      vt.push_back(mk(0, 0, 32'h103C, 4'hF, 32'h0,        1, 0, 32'h0BADF00D, 1));
      vt.push_back(mk(2, 1, 32'h1008, 4'hF, 32'h13579BDF, 1, 0, 32'h0,        1));
      vt.push_back(mk(2, 1, 32'h1004, 4'hF, 32'h55555555, 0, 1, 32'h0,        1));
      vt.push_back(mk(2, 1, 32'h1000, 4'hF, 32'h55555555, 0, 1, 32'h0,        1));
      vt.push_back(mk(2, 0, 32'h1008, 4'hF, 32'h0,        1, 0, 32'h13579BDF, 1));
      vt.push_back(mk(1, 1, 32'h1000, 4'hF, 32'h01020304, 1, 0, 32'h0,        4));
      vt.push_back(mk(1, 0, 32'h1000, 4'hF, 32'h0,        1, 0, 32'h01020304, 4));
      vt.push_back(mk(1, 0, 32'h1002, 4'hF, 32'h0,        0, 1, 32'h0,        4));
      vt.push_back(mk(1, 1, 32'h1008, 4'hF, 32'h12345678, 1, 0, 32'h0,        4));

      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
         chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
         chk($sformatf("rst_rty%0d", d), 32'(rty[d]), 32'd0);
         chk($sformatf("rst_dat%0d", d), drd[d], 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      foreach (vt[i]) begin
         xfer(int'(vt[i].d), vt[i].w, vt[i].a, vt[i].s, vt[i].wd, gack, gerr, rd, lat, tail);
         chk($sformatf("v%0d_ack", i),  32'(gack), 32'(vt[i].eack));
         chk($sformatf("v%0d_err", i),  32'(gerr), 32'(vt[i].eerr));
         chk($sformatf("v%0d_dat", i),  rd, vt[i].erd);
         chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vt[i].elat));
         chk($sformatf("v%0d_tail", i), 32'(tail), 32'd0);
      end

      // ROM word must keep whatever it held before the rejected write
      xfer(2, 1'b0, 32'h1004, 4'hF, 32'h0, gack, gerr, rd, lat, tail);
      chk("rom_rd_ack", 32'(gack), 32'd1);
      chk("rom_unchanged", 32'(rd !== 32'h55555555), 32'd1);

      // Abort: drop strobe in the second wait cycle
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h1000; sel[1] = 4'hF;
      @(negedge clk);
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      watch_quiet(1, 8, hits);
      chk("abort_quiet", 32'(hits), 32'd0);
      xfer(1, 1'b0, 32'h1000, 4'hF, 32'h0, gack, gerr, rd, lat, tail);
      chk("abort_then_lat", 32'(lat), 32'd4);
      chk("abort_then_dat", rd, 32'h01020304);

      // Reset in WAIT of a write must drop it
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h1008; sel[1] = 4'hF;
      dwr[1] = 32'h5A5A5A5A;
      @(negedge clk);
      rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      watch_quiet(1, 8, hits);
      chk("rstwait_quiet", 32'(hits), 32'd0);
      xfer(1, 1'b0, 32'h1008, 4'hF, 32'h0, gack, gerr, rd, lat, tail);
      chk("rstwait_ack", 32'(gack), 32'd1);
      chk("rstwait_dat", rd, 32'h12345678);

      // Reset wins over a simultaneous request
      rst = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h1004; sel[0] = 4'hF;
      @(negedge clk);
      rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      watch_quiet(0, 4, hits);
      chk("rstreq_quiet", 32'(hits), 32'd0);

      // Back-to-back reads with the request held
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h1004; sel[0] = 4'hF;
      nack = 0; consec = 0; baddat = 0; prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[0]) begin
            nack++;
            if (prev) consec++;
            if (drd[0] !== 32'hDEADBEEF) baddat++;
         end else if (drd[0] !== 32'h0) begin
            baddat++;
         end
         prev = ack[0];
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk);
      chk("b2b_acks", 32'(nack), 32'd4);
      chk("b2b_consec", 32'(consec), 32'd0);
      chk("b2b_dat", 32'(baddat), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
